// File: rtl/regfile_pkg.sv
// Shared register-file constants and the helper used by the write-arbiter stats path.
package regfile_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int NUM_REGS = 32;
    localparam logic [4:0] ZERO_REG = 5'd0;

    // True when at least two bits of the (zero-extended) request vector are set.
    function automatic logic popcount_ge2(input logic [7:0] vec);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'd0, vec[i]};
        end
        return (cnt >= 4'd2);
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo NREQ.
module rr_priority_pick #(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any
);

    // Walk the requests starting at ptr; the first hit wins, later hits are masked by any.
    always_comb begin
        int  idx_v;
        logic hit_s;
        gnt     = {NREQ{1'b0}};
        gnt_idx = {IDX_W{1'b0}};
        any     = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx_v = int'(ptr) + k;
            idx_v = (idx_v >= NREQ) ? (idx_v - NREQ) : idx_v;
            hit_s = ~any & req[idx_v];
            gnt[idx_v] = gnt[idx_v] | hit_s;
            gnt_idx = hit_s ? IDX_W'(idx_v) : gnt_idx;
            any = any | hit_s;
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register-file write port; r0 writes are accepted but dropped.
// Optional conflict statistics counter is built when RFWA_STATS_EN is defined.
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int ADDR_W = regfile_pkg::ADDR_W,
    parameter int DATA_W = regfile_pkg::DATA_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    input  logic                     rf_stall,
    output logic                     rf_we,
    output logic [ADDR_W-1:0]        rf_waddr,
    output logic [DATA_W-1:0]        rf_wdata
`ifdef RFWA_STATS_EN
    ,
    output logic [15:0]              conflict_cnt
`endif
);

    localparam int IDX_W = $clog2(NREQ);

    logic [IDX_W-1:0]  rr_ptr_r;
    logic [NREQ-1:0]   gnt_s;
    logic [IDX_W-1:0]  gnt_idx_s;
    logic              any_s;
    logic              accept_s;
    logic [IDX_W-1:0]  ptr_next_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_data_s;
    logic              rf_we_r;
    logic [ADDR_W-1:0] rf_waddr_r;
    logic [DATA_W-1:0] rf_wdata_r;

    rr_priority_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req     (req_valid),
        .ptr     (rr_ptr_r),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s),
        .any     (any_s)
    );

    // Grant gating and winner selection from the flattened request buses.
    always_comb begin
        if (reset || rf_stall) begin
            req_ready = {NREQ{1'b0}};
            accept_s  = 1'b0;
        end else begin
            req_ready = gnt_s;
            accept_s  = any_s;
        end
        ptr_next_s = (gnt_idx_s == IDX_W'(NREQ - 1)) ? {IDX_W{1'b0}} : (gnt_idx_s + {{(IDX_W-1){1'b0}}, 1'b1});
        sel_addr_s = req_addr[int'(gnt_idx_s)*ADDR_W +: ADDR_W];
        sel_data_s = req_data[int'(gnt_idx_s)*DATA_W +: DATA_W];
    end

    // Pointer advance and write-port register; address/data hold when nothing is accepted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr_r   <= {IDX_W{1'b0}};
            rf_we_r    <= 1'b0;
            rf_waddr_r <= {ADDR_W{1'b0}};
            rf_wdata_r <= {DATA_W{1'b0}};
        end else if (accept_s) begin
            rr_ptr_r   <= ptr_next_s;
            rf_we_r    <= (sel_addr_s != ADDR_W'(ZERO_REG));
            rf_waddr_r <= sel_addr_s;
            rf_wdata_r <= sel_data_s;
        end else begin
            rf_we_r    <= 1'b0;
        end
    end

    assign rf_we    = rf_we_r;
    assign rf_waddr = rf_waddr_r;
    assign rf_wdata = rf_wdata_r;

`ifdef RFWA_STATS_EN
    logic [15:0] conflict_cnt_r;

    // Saturating count of unstalled cycles with competing requesters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            conflict_cnt_r <= 16'd0;
        end else if (!rf_stall && popcount_ge2(8'(req_valid)) && (conflict_cnt_r != 16'hFFFF)) begin
            conflict_cnt_r <= conflict_cnt_r + 16'd1;
        end else begin
            conflict_cnt_r <= conflict_cnt_r;
        end
    end

    assign conflict_cnt = conflict_cnt_r;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed-vector bench for regfile_wr_arbiter; exercises the stats counter when RFWA_STATS_EN is defined.
module tb_regfile_wr_arbiter;

    logic         clock;
    logic         reset;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [19:0]  req_addr;
    logic [127:0] req_data;
    logic         rf_stall;
    logic         rf_we;
    logic [4:0]   rf_waddr;
    logic [31:0]  rf_wdata;
`ifdef RFWA_STATS_EN
    logic [15:0]  conflict_cnt;
`endif

    int vecs = 0;
    int errs = 0;

    regfile_wr_arbiter dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .rf_stall  (rf_stall),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata)
`ifdef RFWA_STATS_EN
        ,
        .conflict_cnt (conflict_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
        req_addr[i*5 +: 5]  = a;
        req_data[i*32 +: 32] = d;
    endtask

    task automatic default_reqs();
        for (int i = 0; i < 4; i++) set_req(i, 5'(8 + i), 32'h1000 + 32'(i));
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        req_valid = 4'b0000;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        vecs++; if (req_ready !== 4'b0000) begin $display("FAIL reset_ready: got %b want 0000", req_ready); errs++; end
        vecs++; if (rf_we !== 1'b0) begin $display("FAIL reset_we: got %b want 0", rf_we); errs++; end
        vecs++; if (rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin $display("FAIL reset_regs: got %h/%h want 0/0", rf_waddr, rf_wdata); errs++; end
        @(negedge clock);
        reset = 1'b0;
        #1;
        vecs++; if (req_ready !== 4'b0001) begin $display("FAIL release_ready: got %b want 0001", req_ready); errs++; end
        @(posedge clock); #1;
        vecs++; if (rf_we !== 1'b1 || rf_waddr !== 5'd8 || rf_wdata !== 32'h1000) begin
            $display("FAIL release_write: got we=%b a=%h d=%h want 1/08/00001000", rf_we, rf_waddr, rf_wdata); errs++; end
        @(negedge clock);
        req_valid = 4'b0000;
    endtask

    task automatic test_single();
        req_valid = 4'b0010;
        set_req(1, 5'd5, 32'hDEADBEEF);
        #1;
        vecs++; if (req_ready !== 4'b0010) begin $display("FAIL single_ready: got %b want 0010", req_ready); errs++; end
        @(posedge clock); #1;
        vecs++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
            $display("FAIL single_write: got we=%b a=%h d=%h want 1/05/deadbeef", rf_we, rf_waddr, rf_wdata); errs++; end
        @(negedge clock);
        req_valid = 4'b0000;
        @(posedge clock); #1;
        vecs++; if (rf_we !== 1'b0 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
            $display("FAIL single_idle: got we=%b a=%h d=%h want 0/05/deadbeef", rf_we, rf_waddr, rf_wdata); errs++; end
        @(negedge clock);
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_g;
        do_reset();
        default_reqs();
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            exp_g = 4'b0001 << (k % 4);
            #1;
            vecs++; if (req_ready !== exp_g) begin $display("FAIL rr_ready[%0d]: got %b want %b", k, req_ready, exp_g); errs++; end
            @(posedge clock); #1;
            vecs++; if (rf_we !== 1'b1 || rf_waddr !== 5'(8 + k % 4) || rf_wdata !== 32'h1000 + 32'(k % 4)) begin
                $display("FAIL rr_write[%0d]: got we=%b a=%h d=%h want 1/%h/%h", k, rf_we, rf_waddr, rf_wdata, 5'(8 + k % 4), 32'h1000 + 32'(k % 4)); errs++; end
            @(negedge clock);
        end
        req_valid = 4'b0000;
        @(posedge clock); #1;
        vecs++; if (rf_we !== 1'b0) begin $display("FAIL rr_end_we: got %b want 0", rf_we); errs++; end
        @(negedge clock);
    endtask

    task automatic test_zero_reg();
        req_valid = 4'b0100;
        set_req(2, 5'd0, 32'h1234);
        #1;
        vecs++; if (req_ready !== 4'b0100) begin $display("FAIL r0_ready: got %b want 0100", req_ready); errs++; end
        @(posedge clock); #1;
        vecs++; if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'h1234) begin
            $display("FAIL r0_write: got we=%b a=%h d=%h want 0/00/00001234", rf_we, rf_waddr, rf_wdata); errs++; end
        @(negedge clock);
        req_valid = 4'b1111;
        #1;
        vecs++; if (req_ready !== 4'b1000) begin $display("FAIL r0_ptr: got %b want 1000", req_ready); errs++; end
        req_valid = 4'b0000;
        @(negedge clock);
    endtask

    task automatic test_stall();
        req_valid = 4'b0010;
        set_req(1, 5'd7, 32'h77);
        @(negedge clock);
        rf_stall = 1'b1;
        req_valid = 4'b1010;
        #1;
        vecs++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7) begin $display("FAIL stall_inflight: got we=%b a=%h want 1/07", rf_we, rf_waddr); errs++; end
        for (int k = 0; k < 3; k++) begin
            vecs++; if (req_ready !== 4'b0000) begin $display("FAIL stall_ready[%0d]: got %b want 0000", k, req_ready); errs++; end
            @(posedge clock); #1;
            vecs++; if (rf_we !== 1'b0) begin $display("FAIL stall_we[%0d]: got %b want 0", k, rf_we); errs++; end
            @(negedge clock);
        end
        rf_stall = 1'b0;
        #1;
        vecs++; if (req_ready !== 4'b1000) begin $display("FAIL stall_release: got %b want 1000", req_ready); errs++; end
        @(posedge clock); #1;
        vecs++; if (rf_we !== 1'b1 || rf_waddr !== 5'd11 || rf_wdata !== 32'h1003) begin
            $display("FAIL stall_write: got we=%b a=%h d=%h want 1/0b/00001003", rf_we, rf_waddr, rf_wdata); errs++; end
        @(negedge clock);
        req_valid = 4'b0000;
    endtask

`ifdef RFWA_STATS_EN
    task automatic test_stats();
        do_reset();
        req_valid = 4'b0111;
        @(posedge clock); #1;
        vecs++; if (conflict_cnt !== 16'd1) begin $display("FAIL stats_first: got %h want 0001", conflict_cnt); errs++; end
        @(negedge clock);
        rf_stall = 1'b1;
        @(posedge clock); #1;
        vecs++; if (conflict_cnt !== 16'd1) begin $display("FAIL stats_stall: got %h want 0001", conflict_cnt); errs++; end
        @(negedge clock);
        rf_stall = 1'b0;
        req_valid = 4'b0001;
        @(posedge clock); #1;
        vecs++; if (conflict_cnt !== 16'd1) begin $display("FAIL stats_single: got %h want 0001", conflict_cnt); errs++; end
        @(negedge clock);
        req_valid = 4'b0111;
        repeat (70000) @(posedge clock);
        #1;
        vecs++; if (conflict_cnt !== 16'hFFFF) begin $display("FAIL stats_sat: got %h want ffff", conflict_cnt); errs++; end
        @(negedge clock);
        reset = 1'b1;
        #1;
        vecs++; if (conflict_cnt !== 16'd0) begin $display("FAIL stats_reset: got %h want 0000", conflict_cnt); errs++; end
        @(negedge clock);
        reset = 1'b0;
        req_valid = 4'b0000;
    endtask
`endif

    initial begin
        reset = 1'b1;
        rf_stall = 1'b0;
        req_valid = 4'b1111;
        default_reqs();
        test_reset();
        test_single();
        test_back_to_back();
        test_zero_reg();
        test_stall();
`ifdef RFWA_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
